// File: rtl/cpu_pkg.sv
// Shared definitions for the miniCPU execution controller: opcodes,
// write-data select encodings, sequencer states and instruction field slices.
package cpu_pkg;

    localparam int INSTR_W = 18;

    // Opcode encodings carried in instruction bits [17:15]
    localparam logic [2:0] OP_LOAD    = 3'b000;
    localparam logic [2:0] OP_ADD     = 3'b001;
    localparam logic [2:0] OP_ADDI    = 3'b010;
    localparam logic [2:0] OP_SUB     = 3'b011;
    localparam logic [2:0] OP_SUBI    = 3'b100;
    localparam logic [2:0] OP_MUL     = 3'b101;
    localparam logic [2:0] OP_CLEAR   = 3'b110;
    localparam logic [2:0] OP_DISPLAY = 3'b111;

    // Register-file write-data select
    localparam logic [1:0] WR_ALU  = 2'b00;
    localparam logic [1:0] WR_IMM  = 2'b01;
    localparam logic [1:0] WR_ZERO = 2'b10;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CLR  = 2'd2,
        LCD  = 2'd3
    } state_t;

    // Instruction field bit positions (rs2 and the immediate overlap)
    localparam int OP_MSB  = 17;
    localparam int OP_LSB  = 15;
    localparam int RD_MSB  = 14;
    localparam int RD_LSB  = 11;
    localparam int RS1_MSB = 10;
    localparam int RS1_LSB = 7;
    localparam int RS2_MSB = 6;
    localparam int RS2_LSB = 3;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/button_debouncer.sv
// Send-button conditioner: 2-flop synchronizer followed by either a
// stability counter (CPU_CTRL_DEBOUNCE_EN defined) or a plain rising-edge
// detector (macro undefined). Produces a one-cycle rel_evt on release (0->1).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic rel_evt
);

    logic sync_1;
    logic sync_2;

    // Synchronize the raw button; reset to the released level so no event fires after reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= button;
            sync_2 <= sync_1;
        end
    end

`ifdef CPU_CTRL_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Accept a new level only after it differs from the stable one for DEBOUNCE_CYCLES cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable  <= 1'b1;
            cnt     <= '0;
            rel_evt <= 1'b0;
        end else begin
            rel_evt <= 1'b0;
            if (sync_2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable  <= sync_2;
                cnt     <= '0;
                rel_evt <= sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    logic prev;

    // Plain rising-edge detect on the synchronized button
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev    <= 1'b1;
            rel_evt <= 1'b0;
        end else begin
            prev    <= sync_2;
            rel_evt <= sync_2 & ~prev;
        end
    end
`endif

endmodule

// File: rtl/cpu_exec_controller.sv
// miniCPU execution sequencer: latches the switch instruction on a button
// release, strobes register-file writes (single write or 16-entry CLEAR
// sweep) and hands one request per instruction to the LCD driver.
// Optional debouncer counter is enabled by the CPU_CTRL_DEBOUNCE_EN macro.
module cpu_exec_controller
    import cpu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        botao_enviar,
    input  logic [17:0] instrucao,
    output logic [2:0]  opcode_q,
    output logic [3:0]  write_addr,
    output logic [3:0]  read_addr_1,
    output logic [3:0]  read_addr_2,
    output logic [6:0]  imm_q,
    output logic [1:0]  wr_src,
    output logic        reg_write,
    output logic        lcd_valid,
    input  logic        lcd_ready,
    output logic [2:0]  lcd_op,
    output logic [3:0]  lcd_reg,
    output logic        busy,
    output logic        drop
);

    logic               rel_evt;
    logic [INSTR_W-1:0] instr_q;
    state_t             state;
    logic [3:0]         k;

    logic [2:0] in_op;
    logic [3:0] in_rd;
    logic [3:0] in_rs1;

    assign in_op  = instrucao[OP_MSB:OP_LSB];
    assign in_rd  = instrucao[RD_MSB:RD_LSB];
    assign in_rs1 = instrucao[RS1_MSB:RS1_LSB];

    // Datapath-facing fields are taken directly from the latched instruction
    assign opcode_q    = instr_q[OP_MSB:OP_LSB];
    assign read_addr_1 = instr_q[RS1_MSB:RS1_LSB];
    assign read_addr_2 = instr_q[RS2_MSB:RS2_LSB];
    assign imm_q       = instr_q[IMM_MSB:IMM_LSB];

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock   (clock),
        .reset   (reset),
        .button  (botao_enviar),
        .rel_evt (rel_evt)
    );

    // Sequencer FSM with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            instr_q    <= '0;
            k          <= '0;
            write_addr <= '0;
            wr_src     <= WR_ALU;
            reg_write  <= 1'b0;
            lcd_valid  <= 1'b0;
            lcd_op     <= '0;
            lcd_reg    <= '0;
            busy       <= 1'b0;
            drop       <= 1'b0;
        end else begin
            drop <= 1'b0;
            // A release arriving while an instruction is in flight is discarded
            if (rel_evt && (state != IDLE)) begin
                drop <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (rel_evt) begin
                        instr_q <= instrucao;
                        busy    <= 1'b1;
                        lcd_op  <= in_op;
                        lcd_reg <= (in_op == OP_DISPLAY) ? in_rs1 : in_rd;
                        case (in_op)
                            OP_CLEAR: begin
                                state      <= CLR;
                                k          <= '0;
                                write_addr <= '0;
                                wr_src     <= WR_ZERO;
                                reg_write  <= 1'b1;
                            end
                            OP_DISPLAY: begin
                                state     <= LCD;
                                lcd_valid <= 1'b1;
                            end
                            default: begin
                                state      <= EXEC;
                                write_addr <= in_rd;
                                wr_src     <= (in_op == OP_LOAD) ? WR_IMM : WR_ALU;
                                reg_write  <= 1'b1;
                            end
                        endcase
                    end
                end
                EXEC: begin
                    reg_write <= 1'b0;
                    lcd_valid <= 1'b1;
                    state     <= LCD;
                end
                CLR: begin
                    if (k == 4'd15) begin
                        reg_write <= 1'b0;
                        lcd_valid <= 1'b1;
                        state     <= LCD;
                    end else begin
                        k          <= k + 4'd1;
                        write_addr <= k + 4'd1;
                    end
                end
                LCD: begin
                    if (lcd_ready) begin
                        lcd_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_exec_controller.sv
// Scoreboard bench for cpu_exec_controller (DEBOUNCE_CYCLES=4). Expected
// register writes and LCD transfers are queued when stimulus is applied and
// consumed by a monitor when the DUT produces them.
module tb_cpu_exec_controller;

    logic        clock;
    logic        reset;
    logic        botao_enviar;
    logic [17:0] instrucao;
    logic [2:0]  opcode_q;
    logic [3:0]  write_addr;
    logic [3:0]  read_addr_1;
    logic [3:0]  read_addr_2;
    logic [6:0]  imm_q;
    logic [1:0]  wr_src;
    logic        reg_write;
    logic        lcd_valid;
    logic        lcd_ready;
    logic [2:0]  lcd_op;
    logic [3:0]  lcd_reg;
    logic        busy;
    logic        drop;

    typedef struct packed {
        logic [3:0] addr;
        logic [1:0] src;
    } wr_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] rg;
    } lcd_t;

    wr_t  exp_wr[$];
    lcd_t exp_lcd[$];

    int checks      = 0;
    int failures    = 0;
    int writes_seen = 0;
    int drops_seen  = 0;

    cpu_exec_controller #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .botao_enviar(botao_enviar),
        .instrucao   (instrucao),
        .opcode_q    (opcode_q),
        .write_addr  (write_addr),
        .read_addr_1 (read_addr_1),
        .read_addr_2 (read_addr_2),
        .imm_q       (imm_q),
        .wr_src      (wr_src),
        .reg_write   (reg_write),
        .lcd_valid   (lcd_valid),
        .lcd_ready   (lcd_ready),
        .lcd_op      (lcd_op),
        .lcd_reg     (lcd_reg),
        .busy        (busy),
        .drop        (drop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Hold the button pressed long enough to debounce, then release it
    task automatic press(input logic [17:0] ins);
        instrucao    = ins;
        botao_enviar = 1'b0;
        tick(10);
        botao_enviar = 1'b1;
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_val(tag, busy, 1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check_val(tag, busy, 0);
    endtask

    // Monitor: consumes expected writes/LCD transfers as the DUT produces them
    always begin : monitor
        wr_t  ew;
        lcd_t el;
        @(negedge clock);
        #1;
        if (reg_write === 1'b1) begin
            writes_seen++;
            $display("wr   addr=%0d src=%0d", write_addr, wr_src);
            check_val("wr_expected", (exp_wr.size() > 0), 1);
            if (exp_wr.size() > 0) begin
                ew = exp_wr.pop_front();
                check_val("wr_addr", write_addr, ew.addr);
                check_val("wr_src", wr_src, ew.src);
            end
        end
        if (lcd_valid === 1'b1 && lcd_ready === 1'b1) begin
            $display("lcd  op=%0d reg=%0d", lcd_op, lcd_reg);
            check_val("lcd_expected", (exp_lcd.size() > 0), 1);
            if (exp_lcd.size() > 0) begin
                el = exp_lcd.pop_front();
                check_val("lcd_op", lcd_op, el.op);
                check_val("lcd_reg", lcd_reg, el.rg);
            end
        end
        if (drop === 1'b1) begin
            drops_seen++;
            $display("drop");
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;
        int w0;

        reset        = 1'b0;
        botao_enviar = 1'b1;
        lcd_ready    = 1'b1;
        instrucao    = '0;
        #1 reset = 1'b1;
        tick(2);

        // Reset state
        check_val("rst_reg_write", reg_write, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_lcd_valid", lcd_valid, 0);
        check_val("rst_drop", drop, 0);
        check_val("rst_wr_src", wr_src, 0);
        check_val("rst_write_addr", write_addr, 0);
        check_val("rst_opcode_q", opcode_q, 0);
        check_val("rst_imm_q", imm_q, 0);
        reset = 1'b0;
        tick(3);
        check_val("post_rst_busy", busy, 0);

        // ADDI rd=3 rs1=1 imm=5
        exp_wr.push_back('{addr: 4'd3, src: 2'b00});
        exp_lcd.push_back('{op: 3'b010, rg: 4'd3});
        press({3'b010, 4'd3, 4'd1, 7'b0000101});
        wait_busy("addi_busy");
        check_val("addi_t1_reg_write", reg_write, 1);
        check_val("addi_t1_lcd_valid", lcd_valid, 0);
        check_val("addi_read_addr_1", read_addr_1, 1);
        check_val("addi_opcode_q", opcode_q, 3'b010);
        check_val("addi_imm_q", imm_q, 7'b0000101);
        tick(1);
        check_val("addi_t2_reg_write", reg_write, 0);
        check_val("addi_t2_lcd_valid", lcd_valid, 1);
        tick(1);
        check_val("addi_t3_busy", busy, 0);
        check_val("addi_t3_lcd_valid", lcd_valid, 0);

        // CLEAR sweep
        for (int i = 0; i < 16; i++) begin
            exp_wr.push_back('{addr: 4'(i), src: 2'b10});
        end
        exp_lcd.push_back('{op: 3'b110, rg: 4'hA});
        tick(2);
        press({3'b110, 4'hA, 4'd0, 7'd0});
        wait_busy("clr_busy");
        for (int i = 0; i < 16; i++) begin
            check_val("clr_reg_write", reg_write, 1);
            check_val("clr_addr", write_addr, i);
            tick(1);
        end
        check_val("clr_t17_lcd_valid", lcd_valid, 1);
        check_val("clr_t17_reg_write", reg_write, 0);
        tick(1);
        check_val("clr_done_busy", busy, 0);

        // DISPLAY rs1=7 with lcd_ready low for 5 cycles
        lcd_ready = 1'b0;
        w0 = writes_seen;
        exp_lcd.push_back('{op: 3'b111, rg: 4'd7});
        tick(2);
        press({3'b111, 4'd2, 4'd7, 7'd0});
        wait_busy("disp_busy");
        for (int c = 1; c <= 6; c++) begin
            check_val("disp_lcd_valid", lcd_valid, 1);
            check_val("disp_lcd_reg", lcd_reg, 7);
            check_val("disp_reg_write", reg_write, 0);
            if (c == 6) lcd_ready = 1'b1;
            tick(1);
        end
        check_val("disp_busy_fall", busy, 0);
        check_val("disp_valid_fall", lcd_valid, 0);
        check_val("disp_no_writes", writes_seen - w0, 0);

        // Bouncing release with the LCD stalled
        lcd_ready = 1'b0;
        w0 = writes_seen;
        d0 = drops_seen;
        exp_wr.push_back('{addr: 4'd5, src: 2'b00});
        exp_lcd.push_back('{op: 3'b001, rg: 4'd5});
        instrucao = {3'b001, 4'd5, 4'd2, 4'd3, 3'd0};
        botao_enviar = 1'b0;
        tick(12);
        for (int i = 0; i < 20; i++) begin
            botao_enviar = (((i / 2) % 2) == 0);
            tick(1);
        end
        botao_enviar = 1'b1;
        tick(15);
        check_val("bounce_busy", busy, 1);
        check_val("bounce_writes", writes_seen - w0, 1);
`ifdef CPU_CTRL_DEBOUNCE_EN
        check_val("bounce_drops", drops_seen - d0, 0);
`else
        check_val("bounce_drops", drops_seen - d0, 5);
`endif
        lcd_ready = 1'b1;
        wait_idle("bounce_idle");

        // Second release while waiting on the LCD
        lcd_ready = 1'b0;
        exp_wr.push_back('{addr: 4'd9, src: 2'b01});
        exp_lcd.push_back('{op: 3'b000, rg: 4'd9});
        tick(2);
        press({3'b000, 4'd9, 4'd3, 7'h11});
        wait_busy("drop_busy");
        check_val("load_wr_src", wr_src, 2'b01);
        d0 = drops_seen;
        press({3'b001, 4'd4, 4'd6, 7'd0});
        tick(12);
        check_val("drop_count", drops_seen - d0, 1);
        check_val("drop_read_addr_1", read_addr_1, 3);
        check_val("drop_opcode_q", opcode_q, 0);
        check_val("drop_lcd_reg", lcd_reg, 9);
        check_val("drop_lcd_valid", lcd_valid, 1);
        lcd_ready = 1'b1;
        wait_idle("drop_idle");

        // Reset in the middle of a CLEAR sweep
        for (int i = 0; i < 16; i++) begin
            exp_wr.push_back('{addr: 4'(i), src: 2'b10});
        end
        exp_lcd.push_back('{op: 3'b110, rg: 4'd1});
        tick(2);
        press({3'b110, 4'd1, 4'd0, 7'd0});
        wait_busy("rclr_busy");
        n = 0;
        while (!(reg_write === 1'b1 && write_addr == 4'd6) && n < 50) begin
            tick(1);
            n++;
        end
        check_val("rclr_reach6", write_addr, 6);
        #2;
        reset = 1'b1;
        exp_wr.delete();
        exp_lcd.delete();
        #1;
        check_val("rclr_reg_write", reg_write, 0);
        check_val("rclr_busy", busy, 0);
        check_val("rclr_lcd_valid", lcd_valid, 0);
        check_val("rclr_write_addr", write_addr, 0);
        tick(2);
        reset = 1'b0;
        tick(2);
        check_val("rclr_idle_busy", busy, 0);
        check_val("rclr_idle_reg_write", reg_write, 0);

        // LOAD after the aborted sweep
        exp_wr.push_back('{addr: 4'd12, src: 2'b01});
        exp_lcd.push_back('{op: 3'b000, rg: 4'd12});
        press({3'b000, 4'd12, 4'd0, 7'h05});
        wait_busy("rload_busy");
        check_val("rload_reg_write", reg_write, 1);
        check_val("rload_write_addr", write_addr, 12);
        check_val("rload_imm_q", imm_q, 7'h05);
        wait_idle("rload_idle");
        tick(3);

        check_val("wr_queue_empty", exp_wr.size(), 0);
        check_val("lcd_queue_empty", exp_lcd.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
